// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg
//   Shared definitions for the MMIO register responder: the per-channel
//   state encoding, the wait-counter width, and the byte offset at which the
//   optional error counter appears (one word past the register bank).
package mmio_responder_pkg;

  localparam int WAIT_WIDTH = 4;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_WAIT    = 2'd1,
    CH_RESPOND = 2'd2
  } channel_state_t;

  function automatic logic [31:0] ERROR_COUNTER_OFFSET(input int reg_count);
    return 32'(reg_count) << 2;
  endfunction

endpackage

// File: rtl/mmio_channel_fsm.sv
// mmio_channel_fsm
//   One request channel (write or read) of the MMIO responder:
//   IDLE -> WAIT -> RESPOND -> IDLE, with WAIT skipped when WAIT_STATES is 0.
//   Requests are only accepted in IDLE; anything arriving later is dropped.
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req, i_payload    request pulse and the fields to latch with it
//   o_ready, o_busy     channel idle / not idle
//   o_done              high for the single RESPOND cycle
//   o_enter_respond     the coming edge moves the channel into RESPOND
//   o_payload           fields of the request being served (the incoming
//                       ones on the accept cycle, the latched ones after)
module mmio_channel_fsm
  import mmio_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int PAYLOAD_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_enter_respond,
  output logic [PAYLOAD_W-1:0] o_payload
);

  localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD =
    WAIT_WIDTH'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  channel_state_t         r_state;
  channel_state_t         w_state_next;
  logic [WAIT_WIDTH-1:0]  r_wait_cnt;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic                   w_accept;

  assign w_accept = (r_state == CH_IDLE) && i_req;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CH_IDLE: begin
        if (i_req) begin
          if (WAIT_STATES > 0) w_state_next = CH_WAIT;
          else                 w_state_next = CH_RESPOND;
        end
      end
      CH_WAIT:    if (r_wait_cnt == '0) w_state_next = CH_RESPOND;
      CH_RESPOND: w_state_next = CH_IDLE;
      default:    w_state_next = CH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= CH_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept)
        r_wait_cnt <= WAIT_LOAD;
      else if ((r_state == CH_WAIT) && (r_wait_cnt != '0))
        r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  // Request fields are data: latched on accept, never reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_payload <= i_payload;
  end

  // With zero wait states the decode on the accept edge must see the
  // incoming fields, since the latch is only being loaded on that edge.
  assign o_payload       = w_accept ? i_payload : r_payload;
  assign o_enter_respond = (w_state_next == CH_RESPOND) && (r_state != CH_RESPOND);
  assign o_ready         = (r_state == CH_IDLE);
  assign o_busy          = (r_state != CH_IDLE);
  assign o_done          = (r_state == CH_RESPOND);

endmodule

// File: rtl/mmio_register_responder.sv
// mmio_register_responder
//   Slave-side responder exposing REG_COUNT 32-bit registers to the bus and to
//   peripheral logic. Independent write and read channels, each with
//   WAIT_STATES idle cycles, read-only protection through RO_MASK and error
//   responses for unmapped offsets.
//   Optional feature macro: MMIO_ERROR_INTERRUPT_EN adds error_interrupt_o and
//   a saturating 8-bit error counter at byte offset REG_COUNT*4 (write clears).
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   write_request_i/address/data/strobe   write request from the interconnect
//   write_done_o/error_o         one-cycle completion and its error flag
//   write_busy_o/ready_o         write channel status
//   read_request_i/address_i     read request
//   read_data_o/done_o/error_o   registered read data and completion
//   read_busy_o/ready_o          read channel status
//   error_interrupt_o            (feature only) pulse on any errored done
//   hw_write_i, hw_data_i        per-register hardware update
//   reg_value_o                  current register contents
module mmio_register_responder
  import mmio_responder_pkg::*;
#(
  parameter int                   REG_COUNT   = 8,
  parameter int                   WAIT_STATES = 1,
  parameter logic [REG_COUNT-1:0] RO_MASK     = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        write_request_i,
  input  logic [31:0]                 write_address_i,
  input  logic [31:0]                 write_data_i,
  input  logic [3:0]                  write_strobe_i,
  output logic                        write_done_o,
  output logic                        write_error_o,
  output logic                        write_busy_o,
  output logic                        write_ready_o,
  input  logic                        read_request_i,
  input  logic [31:0]                 read_address_i,
  output logic [31:0]                 read_data_o,
  output logic                        read_done_o,
  output logic                        read_error_o,
  output logic                        read_busy_o,
  output logic                        read_ready_o,
`ifdef MMIO_ERROR_INTERRUPT_EN
  output logic                        error_interrupt_o,
`endif
  input  logic [REG_COUNT-1:0]        hw_write_i,
  input  logic [REG_COUNT-1:0][31:0]  hw_data_i,
  output logic [REG_COUNT-1:0][31:0]  reg_value_o
);

  localparam int IDX_W = $clog2(REG_COUNT);

  logic [REG_COUNT-1:0][31:0] r_regs;
  logic [31:0]                r_read_data;
  logic                       r_rd_err;
  logic                       r_wr_err;
  logic                       r_wr_commit;

  logic [65:0]      w_wr_pl;
  logic [29:0]      w_wr_word;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_wr_strb;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_unmapped;
  logic             w_wr_err_dec;
  logic             w_wr_done;
  logic             w_wr_enter;

  logic [29:0]      w_rd_word;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_unmapped;
  logic             w_rd_err_dec;
  logic             w_rd_done;
  logic             w_rd_enter;

  // Byte-lane bits are ignored; alignment belongs to the master.
  logic             w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{write_address_i[1:0], read_address_i[1:0]};

  mmio_channel_fsm #(.WAIT_STATES(WAIT_STATES), .PAYLOAD_W(66)) u_wr_fsm (
    .i_clk           (clk_i),
    .i_rst           (rst_i),
    .i_req           (write_request_i),
    .i_payload       ({write_address_i[31:2], write_data_i, write_strobe_i}),
    .o_ready         (write_ready_o),
    .o_busy          (write_busy_o),
    .o_done          (w_wr_done),
    .o_enter_respond (w_wr_enter),
    .o_payload       (w_wr_pl)
  );

  mmio_channel_fsm #(.WAIT_STATES(WAIT_STATES), .PAYLOAD_W(30)) u_rd_fsm (
    .i_clk           (clk_i),
    .i_rst           (rst_i),
    .i_req           (read_request_i),
    .i_payload       (read_address_i[31:2]),
    .o_ready         (read_ready_o),
    .o_busy          (read_busy_o),
    .o_done          (w_rd_done),
    .o_enter_respond (w_rd_enter),
    .o_payload       (w_rd_word)
  );

  assign w_wr_word     = w_wr_pl[65:36];
  assign w_wr_data     = w_wr_pl[35:4];
  assign w_wr_strb     = w_wr_pl[3:0];
  assign w_wr_idx      = w_wr_word[IDX_W-1:0];
  assign w_wr_unmapped = |w_wr_word[29:IDX_W];
  assign w_rd_idx      = w_rd_word[IDX_W-1:0];
  assign w_rd_unmapped = |w_rd_word[29:IDX_W];

`ifdef MMIO_ERROR_INTERRUPT_EN
  localparam logic [31:0] CNT_OFFSET = ERROR_COUNTER_OFFSET(REG_COUNT);

  logic [7:0] r_err_cnt;
  logic       r_wr_clr;
  logic       w_wr_is_cnt;
  logic       w_rd_is_cnt;
  logic       w_irq;

  assign w_wr_is_cnt  = (w_wr_word == CNT_OFFSET[31:2]);
  assign w_rd_is_cnt  = (w_rd_word == CNT_OFFSET[31:2]);
  assign w_wr_err_dec = (w_wr_unmapped && !w_wr_is_cnt) || (!w_wr_unmapped && RO_MASK[w_wr_idx]);
  assign w_rd_err_dec = w_rd_unmapped && !w_rd_is_cnt;
  // Errors from both channels in the same cycle merge into one pulse.
  assign w_irq             = write_error_o || read_error_o;
  assign error_interrupt_o = w_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
      r_wr_clr  <= 1'b0;
    end else begin
      if (w_wr_enter) r_wr_clr <= w_wr_is_cnt;
      // A clear in the same cycle as a new error wins.
      if (w_wr_done && r_wr_clr)
        r_err_cnt <= '0;
      else if (w_irq && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
`else
  assign w_wr_err_dec = w_wr_unmapped || RO_MASK[w_wr_idx];
  assign w_rd_err_dec = w_rd_unmapped;
`endif

  // Decode is resolved on entry to RESPOND so the response flags are registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_err    <= 1'b0;
      r_wr_commit <= 1'b0;
    end else if (w_wr_enter) begin
      r_wr_err    <= w_wr_err_dec;
      r_wr_commit <= !w_wr_unmapped && !RO_MASK[w_wr_idx];
    end
  end

  // Bus commit happens on the edge ending RESPOND. Unstrobed lanes of the
  // addressed register still accept a simultaneous hardware update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_regs <= '0;
    end else begin
      for (int k = 0; k < REG_COUNT; k++) begin
        if (w_wr_done && r_wr_commit && (w_wr_idx == IDX_W'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (w_wr_strb[b])
              r_regs[k][8*b +: 8] <= w_wr_data[8*b +: 8];
            else if (hw_write_i[k])
              r_regs[k][8*b +: 8] <= hw_data_i[k][8*b +: 8];
          end
        end else if (hw_write_i[k]) begin
          r_regs[k] <= hw_data_i[k];
        end
      end
    end
  end

  // Read data is captured from the pre-commit array on entry to RESPOND
  // and held until the next read response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_read_data <= '0;
      r_rd_err    <= 1'b0;
    end else if (w_rd_enter) begin
      r_rd_err <= w_rd_err_dec;
      if (w_rd_err_dec)
        r_read_data <= '0;
`ifdef MMIO_ERROR_INTERRUPT_EN
      else if (w_rd_is_cnt)
        r_read_data <= {24'd0, r_err_cnt};
`endif
      else
        r_read_data <= r_regs[w_rd_idx];
    end
  end

  assign write_done_o  = w_wr_done;
  assign write_error_o = w_wr_done && r_wr_err;
  assign read_done_o   = w_rd_done;
  assign read_error_o  = w_rd_done && r_rd_err;
  assign read_data_o   = r_read_data;
  assign reg_value_o   = r_regs;

endmodule
